// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchroniser, mid-bit sampling, valid/ready byte output
// with single-cycle framing-error and overrun pulses.
module uart_rx #(
    parameter int unsigned CLK_FREQ = 50000000,
    parameter int unsigned BAUD     = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_pin,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int unsigned DIV  = CLK_FREQ / BAUD;
    localparam int unsigned HALF = DIV / 2;
    localparam int unsigned CW   = $clog2(DIV);

    localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_t;

    state_t        state;
    logic          sync1;
    logic          rxs;
    logic          rxs_d;
    logic [CW-1:0] cnt;
    logic [2:0]    bitidx;
    logic [7:0]    shift_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1     <= 1'b1;
            rxs       <= 1'b1;
            rxs_d     <= 1'b1;
            state     <= StIdle;
            cnt       <= '0;
            bitidx    <= '0;
            shift_reg <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            sync1     <= rx_pin;
            rxs       <= sync1;
            rxs_d     <= rxs;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            cnt       <= cnt + 1'b1;

            // A completing byte below may override this clear on the same edge.
            if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end

            unique case (state)
                StIdle: begin
                    cnt <= '0;
                    if (rxs_d && !rxs) begin
                        state <= StStart;
                        busy  <= 1'b1;
                    end
                end
                StStart: begin
                    if (cnt == HALF_M1) begin
                        cnt <= '0;
                        if (!rxs) begin
                            state  <= StData;
                            bitidx <= '0;
                        end else begin
                            // Start bit gone by mid-bit: a glitch, not a frame.
                            state <= StIdle;
                            busy  <= 1'b0;
                        end
                    end
                end
                StData: begin
                    if (cnt == DIV_M1) begin
                        cnt               <= '0;
                        shift_reg[bitidx] <= rxs;
                        bitidx            <= bitidx + 3'd1;
                        if (bitidx == 3'd7) begin
                            state <= StStop;
                        end
                    end
                end
                StStop: begin
                    if (cnt == DIV_M1) begin
                        cnt   <= '0;
                        state <= StIdle;
                        busy  <= 1'b0;
                        if (!rxs) begin
                            frame_err <= 1'b1;
                        end else if (!rx_valid || rx_ready) begin
                            rx_data  <= shift_reg;
                            rx_valid <= 1'b1;
                        end else begin
                            overrun <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= StIdle;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus random frames, all judged
// against a frame-level model of when each byte completes and what it should do.
module tb_uart_rx;

    localparam int unsigned CLK_FREQ = 50000000;
    localparam int unsigned BAUD     = 115200;
    localparam int DIV  = CLK_FREQ / BAUD;
    localparam int HALF = DIV / 2;
    // Edges from driving the start bit low to the stop-sample edge: 2 sync + 1 edge detect.
    localparam int DONE = 3 + HALF + 9 * DIV;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx_pin = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    uart_rx #(
        .CLK_FREQ(CLK_FREQ),
        .BAUD    (BAUD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_pin   (rx_pin),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .frame_err(frame_err),
        .overrun  (overrun),
        .busy     (busy)
    );

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    // Model state: what the consumer side should currently see.
    logic       exp_valid = 1'b0;
    logic [7:0] exp_data  = 8'h00;
    int         exp_fe_cnt = 0;
    int         exp_ov_cnt = 0;
    int         fe_seen = 0;
    int         ov_seen = 0;

    always @(negedge clk) begin
        if (frame_err === 1'b1) fe_seen++;
        if (overrun === 1'b1) ov_seen++;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic check_outs(input string tag, input logic v, input logic [7:0] d,
                              input logic fe, input logic ov, input logic bz);
        check_val({tag, ".valid"}, 32'(rx_valid), 32'(v));
        check_val({tag, ".data"}, 32'(rx_data), 32'(d));
        check_val({tag, ".frame_err"}, 32'(frame_err), 32'(fe));
        check_val({tag, ".overrun"}, 32'(overrun), 32'(ov));
        check_val({tag, ".busy"}, 32'(busy), 32'(bz));
    endtask

    task automatic hold(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic goto_pos(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic goto_neg(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic consume(input string tag);
        rx_ready = 1'b1;
        hold(1);
        rx_ready = 1'b0;
        exp_valid = 1'b0;
        check_val({tag, ".consumed"}, 32'(rx_valid), 32'(0));
        check_val({tag, ".data_kept"}, 32'(rx_data), 32'(exp_data));
    endtask

    // Drives one frame starting now (just after a rising edge); rdy asserts rx_ready so that
    // it is seen on exactly the stop-sample edge.
    task automatic send_frame(input string tag, input logic [7:0] b, input logic stop_ok,
                              input logic rdy);
        int p;
        int c;
        logic fe;
        logic ov;
        p = cyc;
        c = p + DONE;
        rx_pin = 1'b0;
        hold(DIV);
        for (int i = 0; i < 8; i++) begin
            rx_pin = b[i];
            hold(DIV);
        end
        rx_pin = stop_ok;
        goto_pos(c - 1);
        rx_ready = rdy;
        check_outs({tag, ".pre"}, exp_valid, exp_data, 1'b0, 1'b0, 1'b1);

        fe = 1'b0;
        ov = 1'b0;
        if (!stop_ok) begin
            fe = 1'b1;
            if (rdy) exp_valid = 1'b0;
        end else if (!exp_valid || rdy) begin
            exp_valid = 1'b1;
            exp_data  = b;
        end else begin
            ov = 1'b1;
        end
        exp_fe_cnt += int'(fe);
        exp_ov_cnt += int'(ov);

        goto_neg(c);
        rx_ready = 1'b0;
        check_outs({tag, ".done"}, exp_valid, exp_data, fe, ov, 1'b0);
        goto_neg(c + 1);
        check_val({tag, ".fe_pulse_end"}, 32'(frame_err), 32'(0));
        check_val({tag, ".ov_pulse_end"}, 32'(overrun), 32'(0));
        goto_pos(p + 10 * DIV);
        rx_pin = 1'b1;
    endtask

    initial begin
        int p;
        int noisy;

        #5 rst = 1'b1;
        #1 check_outs("reset", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        repeat (25) @(posedge clk);
        #1 rst = 1'b0;

        noisy = 0;
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            if (rx_valid || frame_err || overrun || busy || rx_data != 8'h00) noisy++;
        end
        check_val("idle.quiet_cycles", 32'(noisy), 32'(0));
        hold(1);

        send_frame("a5", 8'hA5, 1'b1, 1'b0);
        hold(20);
        consume("a5");
        hold(20);

        // Three-clock low glitch: START is entered and abandoned at the mid-bit sample.
        p = cyc;
        rx_pin = 1'b0;
        goto_neg(p + 2);
        check_val("glitch.busy_before", 32'(busy), 32'(0));
        goto_neg(p + 3);
        check_val("glitch.busy_start", 32'(busy), 32'(1));
        rx_pin = 1'b1;
        goto_neg(p + 2 + HALF);
        check_val("glitch.busy_last", 32'(busy), 32'(1));
        goto_neg(p + 3 + HALF);
        check_outs("glitch.after", 1'b0, exp_data, 1'b0, 1'b0, 1'b0);
        goto_pos(p + DIV);

        send_frame("3c_bad_stop", 8'h3C, 1'b0, 1'b0);
        hold(DIV);
        send_frame("55", 8'h55, 1'b1, 1'b0);
        hold(10);
        consume("55");
        hold(10);

        send_frame("11", 8'h11, 1'b1, 1'b0);
        send_frame("22_overrun", 8'h22, 1'b1, 1'b0);
        hold(10);
        consume("11");
        hold(10);
        send_frame("11b", 8'h11, 1'b1, 1'b0);
        send_frame("22_same_edge", 8'h22, 1'b1, 1'b1);
        hold(DIV);

        // Reset during data bit 4 of 0xFF while 0x22 is still pending.
        p = cyc;
        rx_pin = 1'b0;
        hold(DIV);
        rx_pin = 1'b1;
        hold(4 * DIV + HALF);
        check_val("abort.busy_mid", 32'(busy), 32'(1));
        rst = 1'b1;
        #1 check_outs("abort.in_reset", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        exp_valid = 1'b0;
        exp_data  = 8'h00;
        hold(5);
        rst = 1'b0;
        goto_pos(p + 12 * DIV);
        check_outs("abort.after", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        send_frame("81", 8'h81, 1'b1, 1'b0);
        hold(10);

        for (int k = 0; k < 6; k++) begin
            logic [7:0] b;
            logic       ok;
            logic       rdy;
            b   = 8'($urandom);
            ok  = ($urandom_range(0, 4) != 0);
            rdy = ($urandom_range(0, 3) == 0);
            send_frame($sformatf("rand%0d", k), b, ok, rdy);
            hold($urandom_range(2, 40));
            if ($urandom_range(0, 1) == 1) begin
                consume($sformatf("rand%0d", k));
                hold(2);
            end
        end

        hold(10);
        check_val("total.frame_err_pulses", 32'(fe_seen), 32'(exp_fe_cnt));
        check_val("total.overrun_pulses", 32'(ov_seen), 32'(exp_ov_cnt));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
